// File: rtl/instr_enc_pkg.sv
// Shared RV32I encoding types: instruction classes, opcodes, imm formats.
// Used by instr_encoder and the control-unit opcode decoder.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    C_LOAD   = 3'd0,
    C_STORE  = 3'd1,
    C_OPIMM  = 3'd2,
    C_LUI    = 3'd3,
    C_OP     = 3'd4,
    C_BRANCH = 3'd5,
    C_JAL    = 3'd6,
    C_JALR   = 3'd7
  } instr_class_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_R = 3'b101
  } imm_src_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic logic [6:0] class_opcode(input instr_class_e c);
    logic [6:0] o;
    unique case (c)
      C_LOAD:   o = OPC_LOAD;
      C_STORE:  o = OPC_STORE;
      C_OPIMM:  o = OPC_OPIMM;
      C_LUI:    o = OPC_LUI;
      C_OP:     o = OPC_OP;
      C_BRANCH: o = OPC_BRANCH;
      C_JAL:    o = OPC_JAL;
      default:  o = OPC_JALR;
    endcase
    return o;
  endfunction

  function automatic imm_src_e class_fmt(input instr_class_e c);
    imm_src_e f;
    unique case (c)
      C_STORE:  f = IMM_S;
      C_LUI:    f = IMM_U;
      C_OP:     f = IMM_R;
      C_BRANCH: f = IMM_B;
      C_JAL:    f = IMM_J;
      default:  f = IMM_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Output FIFO for the encoder: DEPTH x W, synchronous active-high reset.
// Ports: i_push/i_data write tail, i_pop/o_data read head, o_full/o_empty.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: decoded fields -> 32-bit word, queued in
// enc_fifo with valid/ready. Optional imm range check: ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_type,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic               in_alt,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic               out_err,
  output logic [COUNT_W-1:0] enc_count
);

`ifdef ENC_RANGE_CHECK_EN
  localparam int W = 33;
`else
  localparam int W = 32;
`endif

  instr_class_e       w_class;
  imm_src_e           w_fmt;
  logic [6:0]         w_opc;
  logic [2:0]         w_f3;
  logic [11:0]        w_i12;
  logic               w_shift;
  logic [31:0]        w_word;
  logic [W-1:0]       w_wdata;
  logic [W-1:0]       w_rdata;
  logic [W-1:0]       w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [W-1:0]       r_last;
  logic [COUNT_W-1:0] r_cnt;

  assign w_class = instr_class_e'(in_type);
  assign w_fmt   = class_fmt(w_class);
  assign w_opc   = class_opcode(w_class);
  assign w_shift = (w_class == C_OPIMM) &&
                   (in_funct3 == 3'b001 || in_funct3 == 3'b101);

  always_comb begin
    w_f3   = (w_class == C_JALR) ? 3'b000 : in_funct3;
    w_i12  = w_shift ? {1'b0, in_alt, 5'b0, in_imm[4:0]}
                     : in_imm[11:0];
    w_word = '0;
    unique case (w_fmt)
      IMM_I: w_word = {w_i12, in_rs1, w_f3, in_rd, w_opc};
      IMM_S: w_word = {in_imm[11:5], in_rs2, in_rs1, w_f3,
                       in_imm[4:0], w_opc};
      IMM_B: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                       w_f3, in_imm[4:1], in_imm[11], w_opc};
      IMM_J: w_word = {in_imm[20], in_imm[10:1], in_imm[11],
                       in_imm[19:12], in_rd, w_opc};
      IMM_U: w_word = {in_imm[31:12], in_rd, w_opc};
      default: w_word = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, w_f3,
                         in_rd, w_opc};
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic w_err;
  logic w_ok12;
  logic w_ok13;
  logic w_ok21;

  // Value fits a signed N-bit field when all bits above N-2 match the sign.
  assign w_ok12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_ok13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_ok21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    w_err = 1'b0;
    unique case (w_fmt)
      IMM_I: w_err = w_shift ? (|in_imm[31:5]) : !w_ok12;
      IMM_S: w_err = !w_ok12;
      IMM_B: w_err = !w_ok13 || in_imm[0];
      IMM_J: w_err = !w_ok21 || in_imm[0];
      IMM_U: w_err = |in_imm[11:0];
      default: w_err = 1'b0;
    endcase
  end

  assign w_wdata = {w_err, w_word};
  assign out_err = w_head[32];
`else
  assign w_wdata = w_word;
  assign out_err = 1'b0;
`endif

  assign in_ready  = !w_full && !rst;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Hold the last popped word on the outputs while the FIFO is empty.
  assign w_head    = w_empty ? r_last : w_rdata;
  assign out_instr = w_head[31:0];
  assign enc_count = r_cnt;

  enc_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .o_data  (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= '0;
      r_cnt  <= '0;
    end else if (w_pop) begin
      r_last <= w_rdata;
      r_cnt  <= r_cnt + COUNT_W'(1);
    end
  end

endmodule
